// File: rtl/gf2m_mul_arbiter.sv
// gf2m_mul_arbiter: round-robin sharing of one GF(2^m) multiplier
// among NREQ requesters, with a start/done handshake and a watchdog.
//
// Ports:
//   clk, rst_b          clock, asynchronous active-low reset
//   req[NREQ]           per-requester request (held until its gnt)
//   req_op_a/b          packed operands, requester i at [i*M +: M]
//   gnt[NREQ]           one-hot pulse: operands of that requester taken
//   rsp_valid[NREQ]     one-hot pulse: product for that requester
//   rsp_data[M]         product (0 on timeout), held until next capture
//   rsp_err             timeout flag, qualified by rsp_valid
//   busy                high whenever the FSM is not idle
//   mul_start           one-cycle start pulse to the multiplier
//   mul_op_a/b[M]       registered operands to the multiplier
//   mul_done, mul_op_c  multiplier completion pulse and result
module gf2m_mul_arbiter #(
    parameter int M       = 83,
    parameter int NREQ    = 4,
    parameter int TIMEOUT = 64
) (
    input  logic              clk,
    input  logic              rst_b,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ*M-1:0] req_op_a,
    input  logic [NREQ*M-1:0] req_op_b,
    output logic [NREQ-1:0]   gnt,
    output logic [NREQ-1:0]   rsp_valid,
    output logic [M-1:0]      rsp_data,
    output logic              rsp_err,
    output logic              busy,
    output logic              mul_start,
    output logic [M-1:0]      mul_op_a,
    output logic [M-1:0]      mul_op_b,
    input  logic              mul_done,
    input  logic [M-1:0]      mul_op_c
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    // wdog only has to count up to TIMEOUT-1
    localparam int WW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t          state;
    logic [IW-1:0]   owner;
    logic [IW-1:0]   rr_last;
    logic [WW-1:0]   wdog;

    logic [IW-1:0]   win;
    logic            win_ok;

    // Scan starts just after the last winner so a held request is
    // reached within NREQ grants.
    always_comb begin
        int idx;
        win    = '0;
        win_ok = 1'b0;
        idx    = 0;
        for (int k = 1; k <= NREQ; k++) begin
            idx = (int'(rr_last) + k) % NREQ;
            if (!win_ok && req[IW'(idx)]) begin
                win    = IW'(idx);
                win_ok = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state     <= S_IDLE;
            owner     <= '0;
            rr_last   <= IW'(NREQ - 1);
            wdog      <= '0;
            gnt       <= '0;
            rsp_valid <= '0;
            rsp_data  <= '0;
            rsp_err   <= 1'b0;
            busy      <= 1'b0;
            mul_start <= 1'b0;
            mul_op_a  <= '0;
            mul_op_b  <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (win_ok) begin
                        mul_op_a  <= req_op_a[int'(win)*M +: M];
                        mul_op_b  <= req_op_b[int'(win)*M +: M];
                        owner     <= win;
                        rr_last   <= win;
                        gnt       <= NREQ'(1) << win;
                        mul_start <= 1'b1;
                        busy      <= 1'b1;
                        state     <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    gnt       <= '0;
                    mul_start <= 1'b0;
                    wdog      <= '0;
                    state     <= S_WAIT;
                end
                S_WAIT: begin
                    wdog <= wdog + 1'b1;
                    // a done in the last watchdog cycle still wins
                    if (mul_done) begin
                        rsp_data  <= mul_op_c;
                        rsp_valid <= NREQ'(1) << owner;
                        rsp_err   <= 1'b0;
                        state     <= S_RESP;
                    end else if (wdog == WW'(TIMEOUT - 1)) begin
                        rsp_data  <= '0;
                        rsp_valid <= NREQ'(1) << owner;
                        rsp_err   <= 1'b1;
                        state     <= S_RESP;
                    end
                end
                S_RESP: begin
                    rsp_valid <= '0;
                    rsp_err   <= 1'b0;
                    busy      <= 1'b0;
                    state     <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gf2m_mul_arbiter.sv
// tb_gf2m_mul_arbiter: table vectors plus corner-case sequences,
// responses checked against a scoreboard queue.
module tb_gf2m_mul_arbiter;

    localparam int M       = 83;
    localparam int NREQ    = 4;
    localparam int TIMEOUT = 64;
    localparam int LAT     = 5;

    logic              clk = 1'b0;
    logic              rst_b;
    logic [NREQ-1:0]   req;
    logic [NREQ*M-1:0] req_op_a;
    logic [NREQ*M-1:0] req_op_b;
    logic [NREQ-1:0]   gnt;
    logic [NREQ-1:0]   rsp_valid;
    logic [M-1:0]      rsp_data;
    logic              rsp_err;
    logic              busy;
    logic              mul_start;
    logic [M-1:0]      mul_op_a;
    logic [M-1:0]      mul_op_b;
    logic              mul_done;
    logic [M-1:0]      mul_op_c;

    logic [M-1:0] opa [NREQ];
    logic [M-1:0] opb [NREQ];

    gf2m_mul_arbiter #(.M(M), .NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
        .clk       (clk),
        .rst_b     (rst_b),
        .req       (req),
        .req_op_a  (req_op_a),
        .req_op_b  (req_op_b),
        .gnt       (gnt),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .rsp_err   (rsp_err),
        .busy      (busy),
        .mul_start (mul_start),
        .mul_op_a  (mul_op_a),
        .mul_op_b  (mul_op_b),
        .mul_done  (mul_done),
        .mul_op_c  (mul_op_c)
    );

    always #5 clk = ~clk;

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            req_op_a[i*M +: M] = opa[i];
            req_op_b[i*M +: M] = opb[i];
        end
    end

    // multiplier stand-in: x^83 + x^7 + x^4 + x^2 + 1
    function automatic logic [M-1:0] gf_mul(input logic [M-1:0] a,
                                            input logic [M-1:0] b);
        logic [M-1:0] r;
        logic [M-1:0] x;
        logic [M-1:0] poly;
        r    = '0;
        x    = a;
        poly = '0;
        poly[7:0] = 8'h95;
        for (int i = 0; i < M; i++) begin
            if (b[i]) r = r ^ x;
            x = x[M-1] ? ((x << 1) ^ poly) : (x << 1);
        end
        return r;
    endfunction

    logic         model_done = 1'b0;
    logic [M-1:0] model_c = '0;
    logic         armed = 1'b0;
    int           cnt = 0;
    logic         hang = 1'b0;
    logic         spur_done = 1'b0;
    logic [M-1:0] spur_c = '0;

    assign mul_done = model_done | spur_done;
    assign mul_op_c = spur_done ? spur_c : model_c;

    always @(posedge clk) begin
        model_done <= 1'b0;
        if (mul_start) begin
            armed <= 1'b1;
            cnt   <= LAT - 1;
        end else if (armed) begin
            if (cnt == 0) begin
                armed <= 1'b0;
                if (!hang) begin
                    model_done <= 1'b1;
                    model_c    <= gf_mul(mul_op_a, mul_op_b);
                end
            end else begin
                cnt <= cnt - 1;
            end
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [M-1:0] act,
                       input logic [M-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    function automatic logic [NREQ-1:0] oh(input int i);
        logic [NREQ-1:0] v;
        v    = '0;
        v[i] = 1'b1;
        return v;
    endfunction

    typedef struct {
        logic [NREQ-1:0] oh;
        logic [M-1:0]    c;
        logic            err;
    } exp_t;

    exp_t sb[$];
    logic prev_done = 1'b0;

    always @(negedge clk) begin
        exp_t e;
        if (rsp_valid != '0) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_rsp: rsp_valid=%b expected none",
                         rsp_valid);
            end else begin
                e = sb.pop_front();
                chk("rsp_valid", M'(rsp_valid), M'(e.oh));
                chk("rsp_data", rsp_data, e.c);
                chk("rsp_err", M'(rsp_err), M'(e.err));
                if (!e.err) chk("rsp_after_done", M'(prev_done), M'(1));
            end
        end
        prev_done = mul_done;
    end

    task automatic wait_gnt();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (gnt == '0 && n < 100);
        if (gnt == '0) begin
            checks++;
            errors++;
            $display("FAIL gnt_wait: got no gnt expected gnt within 100");
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: got %0d pending expected 0", sb.size());
            sb.delete();
        end
        @(negedge clk);
    endtask

    typedef struct {
        int           id;
        logic [M-1:0] a;
        logic [M-1:0] b;
        logic [M-1:0] c;
    } vec_t;

    vec_t vt[8];

    initial begin
        logic [M-1:0] one;
        logic [M-1:0] x82;
        logic [M-1:0] x81;
        logic [M-1:0] xx;
        int n;
        logic late_seen;

        one = 1;
        x82 = one << 82;
        x81 = one << 81;
        xx  = '0;
        xx[50:0] = 51'h5_a5a5_1234_beef;

        vt[0] = '{0, 2,          x82,    'h95};
        vt[1] = '{1, x82,        x82,    x81 | 'h1061};
        vt[2] = '{2, 0,          xx,     0};
        vt[3] = '{3, 1,          xx,     xx};
        vt[4] = '{0, x82 | 1,    2,      'h97};
        vt[5] = '{1, x82,        2,      'h95};
        vt[6] = '{2, 5,          3,      'hF};
        vt[7] = '{3, x81,        4,      'h95};

        rst_b = 1'b0;
        req   = '0;
        for (int i = 0; i < NREQ; i++) begin
            opa[i] = '0;
            opb[i] = '0;
        end
        repeat (3) @(negedge clk);
        rst_b = 1'b1;
        @(negedge clk);
        chk("rst_gnt", M'(gnt), 0);
        chk("rst_rsp_valid", M'(rsp_valid), 0);
        chk("rst_busy", M'(busy), 0);
        chk("rst_mul_start", M'(mul_start), 0);
        chk("rst_rsp_data", rsp_data, 0);
        chk("rst_mul_op_a", mul_op_a, 0);

        for (int v = 0; v < 8; v++) begin
            opa[vt[v].id] = vt[v].a;
            opb[vt[v].id] = vt[v].b;
            req = oh(vt[v].id);
            sb.push_back('{oh(vt[v].id), vt[v].c, 1'b0});
            wait_gnt();
            chk($sformatf("v%0d_gnt", v), M'(gnt), M'(oh(vt[v].id)));
            chk($sformatf("v%0d_start", v), M'(mul_start), 1);
            chk($sformatf("v%0d_busy", v), M'(busy), 1);
            chk($sformatf("v%0d_op_a", v), mul_op_a, vt[v].a);
            chk($sformatf("v%0d_op_b", v), mul_op_b, vt[v].b);
            req = '0;
            drain();
        end

        // all four at once; last grant was 3 so order is 0..3
        for (int i = 0; i < NREQ; i++) begin
            opa[i] = M'(i + 1);
            opb[i] = 3;
        end
        req = 4'b1111;
        sb.push_back('{4'b0001, 'h3, 1'b0});
        sb.push_back('{4'b0010, 'h6, 1'b0});
        sb.push_back('{4'b0100, 'h5, 1'b0});
        sb.push_back('{4'b1000, 'hC, 1'b0});
        for (int k = 0; k < NREQ; k++) begin
            wait_gnt();
            chk($sformatf("all_gnt%0d", k), M'(gnt), M'(oh(k)));
            req[k] = 1'b0;
        end
        drain();

        // round-robin wrap
        opa[0] = 2;
        opb[0] = x82;
        opa[2] = 5;
        opb[2] = 3;
        req = 4'b0100;
        sb.push_back('{4'b0100, 'hF, 1'b0});
        wait_gnt();
        chk("rr_gnt2", M'(gnt), M'(4'b0100));
        req = 4'b0101;
        sb.push_back('{4'b0001, 'h95, 1'b0});
        sb.push_back('{4'b0100, 'hF, 1'b0});
        wait_gnt();
        chk("rr_wrap_gnt0", M'(gnt), M'(4'b0001));
        req[0] = 1'b0;
        wait_gnt();
        chk("rr_again_gnt2", M'(gnt), M'(4'b0100));
        req = '0;
        drain();

        // timeout
        hang   = 1'b1;
        opa[1] = 3;
        opb[1] = 3;
        req = 4'b0010;
        sb.push_back('{4'b0010, '0, 1'b1});
        wait_gnt();
        req = '0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (rsp_valid == '0 && n < 200);
        chk("timeout_cycles", M'(n), M'(TIMEOUT + 1));
        hang = 1'b0;
        drain();
        chk("timeout_idle", M'(busy), 0);
        req = 4'b0100;
        sb.push_back('{4'b0100, 'hF, 1'b0});
        wait_gnt();
        chk("after_to_gnt", M'(gnt), M'(4'b0100));
        req = '0;
        drain();

        // spurious done in IDLE and in ISSUE
        spur_c    = xx;
        spur_done = 1'b1;
        @(negedge clk);
        spur_done = 1'b0;
        chk("spur_idle_rsp", M'(rsp_valid), 0);
        chk("spur_idle_busy", M'(busy), 0);
        req = 4'b0001;
        sb.push_back('{4'b0001, 'h95, 1'b0});
        wait_gnt();
        req       = '0;
        spur_done = 1'b1;
        @(negedge clk);
        spur_done = 1'b0;
        chk("spur_issue_rsp", M'(rsp_valid), 0);
        chk("spur_issue_busy", M'(busy), 1);
        drain();

        // reset while waiting on requester 1
        opa[1] = 7;
        opb[1] = 7;
        req = 4'b0010;
        wait_gnt();
        chk("pre_rst_gnt", M'(gnt), M'(4'b0010));
        req = '0;
        repeat (2) @(negedge clk);
        rst_b = 1'b0;
        #1;
        chk("midrst_busy", M'(busy), 0);
        chk("midrst_gnt", M'(gnt), 0);
        chk("midrst_rsp", M'(rsp_valid), 0);
        @(negedge clk);
        rst_b = 1'b1;
        late_seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (mul_done) late_seen = 1'b1;
        end
        chk("late_done_seen", M'(late_seen), 1);
        chk("late_done_idle", M'(busy), 0);
        for (int i = 0; i < NREQ; i++) begin
            opa[i] = 2;
            opb[i] = x82;
        end
        req = 4'b1111;
        sb.push_back('{4'b0001, 'h95, 1'b0});
        wait_gnt();
        chk("post_rst_gnt", M'(gnt), M'(4'b0001));
        req = '0;
        drain();

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule

// File: doc/gf2m_mul_arbiter.md
Name: gf2m_mul_arbiter

Overview:
- Shares one GF(2^m) multiplier instance (start/done handshake, multi-cycle latency) among NREQ independent requesters using round-robin arbitration.
- Captures the winning requester's operands and pulses the multiplier start.
- Waits for done, then returns the product to the owner on a tagged one-hot response.
- Sits between sequencing FSMs (e.g. scalar steps of the GF(2^m)[z] encrypt flow) and a single gf2m_mul, so scalar GF(2^m) products do not each need a dedicated multiplier.

Parameters:
- M, 83, field width m; operand and result width.
- NREQ, 4, number of requesters (2..8).
- TIMEOUT, 64, maximum cycles in WAIT before abort (must be greater than the multiplier latency).

Ports:
- clk  in  1  system clock.
- rst_b  in  1  asynchronous, active-low reset.
- req  in  NREQ  request per requester; held high with operands stable until the matching gnt bit is seen.
- req_op_a  in  NREQ*M  operand A, requester i at [i*M +: M].
- req_op_b  in  NREQ*M  operand B, same packing.
- gnt  out  NREQ  one-hot, one-cycle pulse: operands of that requester captured.
- rsp_valid  out  NREQ  one-hot, one-cycle pulse: result for that requester on rsp_data.
- rsp_data  out  M  product, valid only while any rsp_valid bit is high.
- rsp_err  out  1  high with rsp_valid when the operation timed out; rsp_data = 0 in that case.
- busy  out  1  high in any state other than IDLE.
- mul_start  out  1  one-cycle start pulse to the multiplier.
- mul_op_a  out  M  registered operand A, stable from ISSUE until the next capture.
- mul_op_b  out  M  registered operand B, same timing.
- mul_done  in  1  one-cycle pulse from the multiplier; mul_op_c is valid in the same cycle.
- mul_op_c  in  M  multiplier result.

Behaviour:
- Reset (async, rst_b = 0): all outputs 0; state = IDLE; owner = 0; rr_last = NREQ-1; wdog = 0.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If req != 0, pick winner w = first set bit scanning rr_last+1, rr_last+2, ... modulo NREQ.
  - At the clock edge: latch req_op_a/b[w] into mul_op_a/b; owner = w; rr_last = w; gnt = onehot(w); mul_start = 1; go to ISSUE.
  - If req == 0, stay in IDLE.
- ISSUE (exactly 1 cycle):
  - gnt and mul_start are high during this cycle.
  - Next edge: clear both, wdog = 0, go to WAIT.
  - req is ignored in this cycle (the winner is still holding req).
- WAIT:
  - wdog increments each cycle.
  - On mul_done: capture mul_op_c into rsp_data, rsp_valid = onehot(owner), rsp_err = 0, go to RESP.
  - If wdog reaches TIMEOUT-1 without mul_done: rsp_data = 0, rsp_valid = onehot(owner), rsp_err = 1, go to RESP.
- RESP (exactly 1 cycle): responses are visible; next edge clears rsp_valid and rsp_err and goes to IDLE.
  - rsp_data holds its value until the next capture.
- Latency: req seen in IDLE at cycle t → gnt at t+1 → mul_start at t+1 → rsp_valid one cycle after the mul_done cycle.
  - Back-to-back throughput: multiplier latency + 3 cycles per operation.
- mul_done outside WAIT is ignored. It has no effect on state or outputs.
- req changes outside IDLE have no effect. A requester that drops req before gnt is simply not granted; its operands are never sampled.
- Fairness: a requester that holds req is granted within NREQ arbitration rounds.
- All state bits are registered; gnt, rsp_valid, mul_start and rsp_err come directly from flops.
- Reset asserted mid-operation: immediate return to reset values. No rsp_valid is produced for the aborted operation. A late mul_done after reset is released is ignored because the FSM is in IDLE.

Test Plan:
- Single request, field polynomial x^83+x^7+x^4+x^2+1: req[0], op_a = 0x2, op_b = 1<<82 → gnt = 4'b0001; mul_op_a/b match the inputs; after mul_done, rsp_valid = 4'b0001 and rsp_data = 0x95 for one cycle; rsp_err = 0.
- Simultaneous requests: req = 4'b1111 held, each requester dropping req after its own gnt → grant order 0, 1, 2, 3; each rsp_valid goes only to its owner with the correct product (op_a = i+1, op_b = 0x3 → rsp_data = 3*(i+1) carry-less).
- Round-robin wrap: after a grant to requester 2, req = 4'b0101 → next grant = 0 (scan 3, 0); then with requester 2 still requesting → grant = 2.
- Timeout: multiplier model never pulses done → exactly TIMEOUT cycles after ISSUE, rsp_valid = owner, rsp_err = 1, rsp_data = 0; FSM returns to IDLE and the next request is served normally.
- Spurious done: mul_done pulsed in IDLE and in ISSUE → no rsp_valid; the real done in WAIT is still accepted.
- Reset mid-WAIT: rst_b low for 1 cycle → busy = 0, gnt = 0, rsp_valid = 0 at once; subsequent mul_done is ignored; the first grant after reset goes to requester 0 when req = 4'b1111.
